// File: rtl/keypoint_reader.sv
`timescale 1ns/1ps
// keypoint_reader: drains the keypoint BRAM through a credit-controlled FIFO onto a {layer,x,y} stream.
// Define KEYPOINT_READER_BORDER_FILTER_EN to discard entries lying on the image border.
module keypoint_reader #(
  parameter int DIMENSION = 64,
  parameter int KEY_DEPTH = DIMENSION * DIMENSION,
  parameter int FIFO_DEPTH = 4,
  localparam int COORD_W = $clog2(DIMENSION),
  localparam int KEY_AW = $clog2(KEY_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [KEY_AW:0]      key_count,
  output logic [KEY_AW-1:0]    key_read_addr,
  input  logic [2*COORD_W:0]   key_read_data,
  output logic                 kp_valid,
  input  logic                 kp_ready,
  output logic                 kp_layer,
  output logic [COORD_W-1:0]   kp_x,
  output logic [COORD_W-1:0]   kp_y,
  output logic                 busy,
  output logic                 done,
  output logic [KEY_AW:0]      dropped_count
);

  localparam int ENTRY_W = 2 * COORD_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [KEY_AW:0] DEPTH_CLAMP = (KEY_AW+1)'(KEY_DEPTH);
  localparam logic [KEY_AW:0] ONE_K = (KEY_AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;

  logic [KEY_AW:0]    n_total, issued, clamped, dropped;
  logic [KEY_AW-1:0]  addr;
  logic [1:0]         pipe;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;
  logic               issue, push, pop, drop, drained;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign clamped = (key_count > DEPTH_CLAMP) ? DEPTH_CLAMP : key_count;

  // Credits: buffered entries plus reads in flight may never exceed the FIFO depth.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(pipe[0]) + (CNT_W+1)'(pipe[1]);
  assign issue = (state == RUN) && (issued != n_total) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

`ifdef KEYPOINT_READER_BORDER_FILTER_EN
  logic [COORD_W-1:0] ret_x, ret_y;
  assign ret_x = key_read_data[2*COORD_W-1:COORD_W];
  assign ret_y = key_read_data[COORD_W-1:0];
  assign drop = pipe[1] && (ret_x == '0 || ret_x == COORD_W'(DIMENSION - 1) ||
                            ret_y == '0 || ret_y == COORD_W'(DIMENSION - 1));
`else
  assign drop = 1'b0;
`endif

  // Stream handshake: a record transfers on every rising edge where kp_valid && kp_ready;
  // while kp_valid is high and kp_ready low the record is held unchanged.
  assign kp_valid = (fifo_count != '0);
  assign pop = kp_valid && kp_ready;
  assign push = pipe[1] && !drop;
  assign drained = (issued == n_total) && (pipe == 2'b00) &&
                   ((fifo_count == '0) || (fifo_count == CNT_W'(1) && pop));

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (clamped == '0) ? FINISH : RUN;
      RUN:     if (drained) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      FINISH:  begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      n_total <= '0;
      issued  <= '0;
      addr    <= '0;
      pipe    <= '0;
      dropped <= '0;
    end else begin
      pipe <= {pipe[0], issue};
      if (state == IDLE && start) begin
        n_total <= clamped;
        issued  <= '0;
        addr    <= '0;
        dropped <= '0;
      end else if (issue) begin
        issued <= issued + ONE_K;
        // Hold the last address instead of stepping past the final entry.
        if (issued + ONE_K != n_total) addr <= addr + KEY_AW'(1);
      end
      if (drop) dropped <= dropped + ONE_K;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= key_read_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign {kp_layer, kp_x, kp_y} = mem[rd_ptr];
  assign key_read_addr = addr;
  assign dropped_count = dropped;

endmodule
